// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch control path: FSM status, command codes
// and command source identifiers.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUNNING = 2'b01,
      PAUSED  = 2'b10
   } status_t;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'b00,
      CMD_START = 2'b01,
      CMD_STOP  = 2'b10,
      CMD_RESET = 2'b11
   } cmd_t;

   localparam logic SRC_BTN  = 1'b0;
   localparam logic SRC_HOST = 1'b1;

endpackage

// File: rtl/stopwatch_cmd_arb_if.sv
// Host register-port handshake into the stopwatch command arbiter: a level
// request with its command code, answered by a one-cycle ack/err pair.
interface stopwatch_cmd_arb_if;
   import stopwatch_pkg::*;

   logic host_req;
   cmd_t host_cmd;
   logic host_ack;
   logic host_err;

   modport master (
      output host_req,
      output host_cmd,
      input  host_ack,
      input  host_err
   );

   modport slave (
      input  host_req,
      input  host_cmd,
      output host_ack,
      output host_err
   );

endinterface

// File: rtl/btn_edge_capture.sv
// Button-side request capture: rising-edge detection and a single prioritized
// pending command, with a pending reset that cannot be displaced by start/stop.
module btn_edge_capture
   import stopwatch_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic btn_start,
   input  logic btn_stop,
   input  logic btn_reset,
   input  logic clr,
   output cmd_t pend
);

   logic prev_start, prev_stop, prev_reset;
   logic rise_start, rise_stop, rise_reset;
   cmd_t pend_nxt;

   assign rise_start = btn_start & ~prev_start;
   assign rise_stop  = btn_stop  & ~prev_stop;
   assign rise_reset = btn_reset & ~prev_reset;

   // A start/stop edge landing on the edge that issues a pending reset is
   // also discarded: the reset owns the slot until it has gone out.
   always_comb begin
      pend_nxt = pend;
      if (rise_reset) begin
         pend_nxt = CMD_RESET;
      end else if (pend == CMD_RESET) begin
         if (clr) pend_nxt = CMD_NOP;
      end else if (rise_stop) begin
         pend_nxt = CMD_STOP;
      end else if (rise_start) begin
         pend_nxt = CMD_START;
      end else if (clr) begin
         pend_nxt = CMD_NOP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_start <= 1'b0;
         prev_stop  <= 1'b0;
         prev_reset <= 1'b0;
         pend       <= CMD_NOP;
      end else begin
         prev_start <= btn_start;
         prev_stop  <= btn_stop;
         prev_reset <= btn_reset;
         pend       <= pend_nxt;
      end
   end

endmodule

// File: rtl/stopwatch_cmd_arb.sv
// Stopwatch command arbiter: merges button and host requests into one-cycle
// start/stop/reset pulses. Optional status filter: STOPWATCH_CMD_FILTER_EN.
module stopwatch_cmd_arb
   import stopwatch_pkg::*;
#(
   parameter int HOLDOFF_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_start,
   input  logic                 btn_stop,
   input  logic                 btn_reset,
   stopwatch_cmd_arb_if.slave   host,
   input  logic [1:0]           status,
   output logic                 start_o,
   output logic                 stop_o,
   output logic                 reset_o,
   output logic                 last_src,
   output logic                 busy
);

   localparam int CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] HOLDOFF_LD = CNT_W'(HOLDOFF_CYCLES);

   cmd_t             btn_pend;
   logic             btn_clr;
   logic             host_vld;
   cmd_t             host_pend;
   logic             host_clr;
   logic             rr;
   logic [CNT_W-1:0] cnt;

   logic             btn_rst, host_rst, host_nop, btn_ss, host_ss;
   logic             grant_host;
   cmd_t             sel;
   logic             drop_sel;

   logic             start_nxt, stop_nxt, reset_nxt, ack_nxt, err_nxt;
   logic             src_nxt, rr_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   btn_edge_capture u_btn (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_stop  (btn_stop),
      .btn_reset (btn_reset),
      .clr       (btn_clr),
      .pend      (btn_pend)
   );

   // Host capture: latch only into an empty slot; the command code is data and
   // is qualified by host_vld, so it carries no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         host_vld <= 1'b0;
      end else if (host_vld) begin
         if (host_clr) host_vld <= 1'b0;
      end else if (host.host_req) begin
         host_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!host_vld && host.host_req) host_pend <= host.host_cmd;
   end

   assign btn_rst  = (btn_pend == CMD_RESET);
   assign host_rst = host_vld && (host_pend == CMD_RESET);
   assign host_nop = host_vld && (host_pend == CMD_NOP);
   assign btn_ss   = (btn_pend == CMD_START) || (btn_pend == CMD_STOP);
   assign host_ss  = host_vld && ((host_pend == CMD_START) || (host_pend == CMD_STOP));

   always_comb begin
      grant_host = host_ss && ((rr == SRC_HOST) || !btn_ss);
      sel        = grant_host ? host_pend : btn_pend;
   end

`ifdef STOPWATCH_CMD_FILTER_EN
   assign drop_sel = ((sel == CMD_START) && (status == RUNNING)) ||
                     ((sel == CMD_STOP)  && (status != RUNNING));
`else
   logic unused_status;
   assign unused_status = ^status;
   assign drop_sel      = 1'b0;
`endif

   always_comb begin
      start_nxt = 1'b0;
      stop_nxt  = 1'b0;
      reset_nxt = 1'b0;
      ack_nxt   = 1'b0;
      err_nxt   = 1'b0;
      src_nxt   = last_src;
      rr_nxt    = rr;
      btn_clr   = 1'b0;
      host_clr  = 1'b0;
      cnt_nxt   = (cnt != '0) ? cnt - CNT_W'(1) : '0;

      if (btn_rst || host_rst) begin
         // Reset ignores holdoff and leaves rr alone; a double reset collapses to one pulse.
         reset_nxt = 1'b1;
         cnt_nxt   = '0;
         btn_clr   = btn_rst;
         if (host_rst) begin
            host_clr = 1'b1;
            ack_nxt  = 1'b1;
            src_nxt  = SRC_HOST;
         end else begin
            src_nxt  = SRC_BTN;
         end
      end else begin
         if (host_nop) begin
            host_clr = 1'b1;
            ack_nxt  = 1'b1;
            err_nxt  = 1'b1;
         end
         if ((cnt == '0) && (btn_ss || host_ss)) begin
            if (grant_host) begin
               host_clr = 1'b1;
               ack_nxt  = 1'b1;
            end else begin
               btn_clr  = 1'b1;
            end
            if (drop_sel) begin
               err_nxt = grant_host;
            end else begin
               start_nxt = (sel == CMD_START);
               stop_nxt  = (sel == CMD_STOP);
               src_nxt   = grant_host ? SRC_HOST : SRC_BTN;
               rr_nxt    = grant_host ? SRC_BTN : SRC_HOST;
               cnt_nxt   = HOLDOFF_LD;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         start_o       <= 1'b0;
         stop_o        <= 1'b0;
         reset_o       <= 1'b0;
         host.host_ack <= 1'b0;
         host.host_err <= 1'b0;
         last_src      <= SRC_BTN;
         busy          <= 1'b0;
         rr            <= SRC_BTN;
         cnt           <= '0;
      end else begin
         start_o       <= start_nxt;
         stop_o        <= stop_nxt;
         reset_o       <= reset_nxt;
         host.host_ack <= ack_nxt;
         host.host_err <= err_nxt;
         last_src      <= src_nxt;
         busy          <= (cnt_nxt != '0);
         rr            <= rr_nxt;
         cnt           <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_stopwatch_cmd_arb.sv
// Scoreboard bench for stopwatch_cmd_arb: each scenario queues the pulses and
// acks it expects, and a negedge monitor matches them against the DUT.
module tb_stopwatch_cmd_arb;
   import stopwatch_pkg::*;

   localparam int H = 4;

   typedef struct {
      int   cyc;
      logic st;
      logic sp;
      logic rs;
      logic ack;
      logic err;
      logic src;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_start, btn_stop, btn_reset;
   logic [1:0] status;
   logic       start_o, stop_o, reset_o, last_src, busy;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb[$];
   exp_t mon_e;

   stopwatch_cmd_arb_if host_if ();

   stopwatch_cmd_arb #(.HOLDOFF_CYCLES(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_stop  (btn_stop),
      .btn_reset (btn_reset),
      .host      (host_if),
      .status    (status),
      .start_o   (start_o),
      .stop_o    (stop_o),
      .reset_o   (reset_o),
      .last_src  (last_src),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required $finish");
      $fatal(1, "watchdog");
   end

   function automatic void exp_ev(int c, logic st, logic sp, logic rs,
                                  logic ack, logic err, logic src);
      exp_t e;
      e = '{c, st, sp, rs, ack, err, src};
      sb.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (start_o || stop_o || reset_o || host_if.host_ack) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event cyc=%0d got st/sp/rs/ack/err=%b%b%b%b%b required none",
                     cyc, start_o, stop_o, reset_o, host_if.host_ack, host_if.host_err);
         end else begin
            mon_e = sb.pop_front();
            if (cyc !== mon_e.cyc || start_o !== mon_e.st || stop_o !== mon_e.sp ||
                reset_o !== mon_e.rs || host_if.host_ack !== mon_e.ack ||
                host_if.host_err !== mon_e.err ||
                ((start_o || stop_o || reset_o) && last_src !== mon_e.src)) begin
               n_fail++;
               $display("FAIL event got cyc=%0d st/sp/rs/ack/err/src=%b%b%b%b%b%b required cyc=%0d %b%b%b%b%b%b",
                        cyc, start_o, stop_o, reset_o, host_if.host_ack, host_if.host_err, last_src,
                        mon_e.cyc, mon_e.st, mon_e.sp, mon_e.rs, mon_e.ack, mon_e.err, mon_e.src);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      btn_start = 1'b0;
      btn_stop  = 1'b0;
      btn_reset = 1'b0;
      host_if.host_req = 1'b0;
      host_if.host_cmd = CMD_NOP;
      status = IDLE;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      int t;
      do_reset();
      @(negedge clk);
      t = cyc;
      host_if.host_req = 1'b1;
      host_if.host_cmd = CMD_START;
      exp_ev(t + 2, 1, 0, 0, 1, 0, 1);
      repeat (2) @(negedge clk);
      host_if.host_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({start_o, stop_o, reset_o} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_pulses got %b required 000", {start_o, stop_o, reset_o});
      end
      n_tests++;
      if ({host_if.host_ack, host_if.host_err} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_ack_err got %b required 00", {host_if.host_ack, host_if.host_err});
      end
      n_tests++;
      if (last_src !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_last_src got %b required 0", last_src);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy got %b required 0", busy);
      end
      rst = 1'b0;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL reset_outstanding got %0d required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_btn_start();
      int  t;
      logic want;
      do_reset();
      @(negedge clk);
      t = cyc;
      btn_start = 1'b1;
      exp_ev(t + 2, 1, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         want = (cyc >= t + 2) && (cyc <= t + 1 + H);
         n_tests++;
         if (busy !== want) begin
            n_fail++;
            $display("FAIL btn_start_busy cyc=%0d got %b required %b", cyc, busy, want);
         end
      end
      btn_start = 1'b0;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL btn_start_outstanding got %0d required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_round_robin();
      int t;
      do_reset();
      status = RUNNING;
      @(negedge clk);
      t = cyc;
      btn_stop = 1'b1;
      host_if.host_req = 1'b1;
      host_if.host_cmd = CMD_STOP;
      exp_ev(t + 2, 0, 1, 0, 0, 0, 0);
      exp_ev(t + 3 + H, 0, 1, 0, 1, 0, 1);
      repeat (12) begin
         @(negedge clk);
         if (host_if.host_ack) host_if.host_req = 1'b0;
      end
      btn_stop = 1'b0;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL round_robin_outstanding got %0d required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset_bypass();
      int t;
      do_reset();
      @(negedge clk);
      t = cyc;
      btn_start = 1'b1;
      exp_ev(t + 2, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      btn_start = 1'b0;
      repeat (2) @(negedge clk);
      host_if.host_req = 1'b1;
      host_if.host_cmd = CMD_START;
      btn_reset = 1'b1;
      exp_ev(t + 5, 0, 0, 1, 0, 0, 0);
      exp_ev(t + 6, 1, 0, 0, 1, 0, 1);
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL bypass_busy_before got %b required 1", busy);
      end
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bypass_busy_after_reset got %b required 0", busy);
      end
      repeat (8) begin
         @(negedge clk);
         if (host_if.host_ack) host_if.host_req = 1'b0;
      end
      btn_reset = 1'b0;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL bypass_outstanding got %0d required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_filter();
      int   t;
      logic want;
      do_reset();
      status = PAUSED;
      @(negedge clk);
      t = cyc;
      host_if.host_req = 1'b1;
      host_if.host_cmd = CMD_STOP;
`ifdef STOPWATCH_CMD_FILTER_EN
      exp_ev(t + 2, 0, 0, 0, 1, 1, 0);
      want = 1'b0;
`else
      exp_ev(t + 2, 0, 1, 0, 1, 0, 1);
      want = 1'b1;
`endif
      repeat (2) @(negedge clk);
      host_if.host_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== want) begin
         n_fail++;
         $display("FAIL filter_stop_busy got %b required %b", busy, want);
      end
      repeat (8) @(negedge clk);
      status = RUNNING;
      @(negedge clk);
      t = cyc;
      btn_start = 1'b1;
`ifndef STOPWATCH_CMD_FILTER_EN
      exp_ev(t + 2, 1, 0, 0, 0, 0, 0);
`endif
      repeat (8) @(negedge clk);
      btn_start = 1'b0;
      @(negedge clk);
      t = cyc;
      host_if.host_req = 1'b1;
      host_if.host_cmd = CMD_NOP;
      exp_ev(t + 2, 0, 0, 0, 1, 1, 0);
      repeat (2) @(negedge clk);
      host_if.host_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL nop_busy got %b required 0", busy);
      end
      repeat (4) @(negedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL filter_outstanding got %0d required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_btn_priority();
      int t;
      do_reset();
      status = RUNNING;
      @(negedge clk);
      t = cyc;
      btn_stop  = 1'b1;
      btn_start = 1'b1;
      exp_ev(t + 2, 0, 1, 0, 0, 0, 0);
      repeat (8) @(negedge clk);
      btn_stop  = 1'b0;
      btn_start = 1'b0;
      @(negedge clk);
      t = cyc;
      btn_reset = 1'b1;
      exp_ev(t + 2, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      btn_start = 1'b1;
      repeat (9) @(negedge clk);
      btn_start = 1'b0;
      btn_reset = 1'b0;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL priority_outstanding got %0d required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_holdoff();
      int t;
      do_reset();
      @(negedge clk);
      t = cyc;
      btn_start = 1'b1;
      exp_ev(t + 2, 1, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      btn_start = 1'b0;
      status    = RUNNING;
      btn_stop  = 1'b1;
      exp_ev(t + 3 + H, 0, 1, 0, 0, 0, 0);
      repeat (10) @(negedge clk);
      btn_stop = 1'b0;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL holdoff_outstanding got %0d required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_rst_mid();
      int t;
      do_reset();
      @(negedge clk);
      t = cyc;
      btn_start = 1'b1;
      exp_ev(t + 2, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      btn_start = 1'b0;
      repeat (8) @(negedge clk);
      host_if.host_req = 1'b1;
      host_if.host_cmd = CMD_START;
      @(negedge clk);
      rst = 1'b1;
      host_if.host_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({start_o, stop_o, reset_o, host_if.host_ack, host_if.host_err} !== 5'b00000) begin
         n_fail++;
         $display("FAIL rst_mid_outputs got %b required 00000",
                  {start_o, stop_o, reset_o, host_if.host_ack, host_if.host_err});
      end
      n_tests++;
      if ({busy, last_src} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_mid_busy_src got %b required 00", {busy, last_src});
      end
      rst = 1'b0;
      t = cyc;
      btn_start = 1'b1;
      host_if.host_req = 1'b1;
      host_if.host_cmd = CMD_START;
      exp_ev(t + 2, 1, 0, 0, 0, 0, 0);
      exp_ev(t + 3 + H, 1, 0, 0, 1, 0, 1);
      repeat (12) begin
         @(negedge clk);
         if (host_if.host_ack) host_if.host_req = 1'b0;
      end
      btn_start = 1'b0;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL rst_mid_outstanding got %0d required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      rst = 1'b1;
      btn_start = 1'b0;
      btn_stop  = 1'b0;
      btn_reset = 1'b0;
      host_if.host_req = 1'b0;
      host_if.host_cmd = CMD_NOP;
      status = IDLE;
      test_reset();
      test_btn_start();
      test_round_robin();
      test_reset_bypass();
      test_filter();
      test_btn_priority();
      test_holdoff();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
